// File: rtl/mixer_pkg.sv
// Shared pan encodings, default tape amplitude and sum-width helper for the N-channel audio mixer.
package mixer_pkg;

    typedef enum logic [1:0] {
        PAN_BOTH  = 2'b00,
        PAN_LEFT  = 2'b01,
        PAN_RIGHT = 2'b10,
        PAN_MUTE  = 2'b11
    } pan_e;

    localparam int unsigned DEFAULT_TAPE_LEVEL = 'h40;

    // Width of the accumulated sum: CW + clog2(NCH+1), grown by one bit only when the
    // real worst case (all channels full scale plus both tape bits) would not fit.
    function automatic int unsigned mix_sum_width(input int unsigned nch, input int unsigned cw,
                                                  input int unsigned tape_level = DEFAULT_TAPE_LEVEL);
        int unsigned     base;
        longint unsigned max_sum;
        longint unsigned cap;
        base    = cw + $clog2(nch + 1);
        max_sum = longint'(nch) * ((64'd1 << cw) - 64'd1) + 64'd2 * longint'(tape_level);
        cap     = (64'd1 << base) - 64'd1;
        return (max_sum > cap) ? base + 1 : base;
    endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta 1-bit DAC: the carry out of a W-bit phase accumulator is the bitstream.
module sigma_delta_dac #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sample,
    output logic         bit_out
);

    logic [W:0] dacc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dacc <= '0;
        end else begin
            dacc <= {1'b0, dacc[W-1:0]} + {1'b0, sample};
        end
    end

    assign bit_out = dacc[W];

endmodule

// File: rtl/audio_mixer_nch.sv
// Time-multiplexed NCH-channel stereo mixer with tape slot and sigma-delta outputs.
// Optional master attenuation via `define MIXER_VOLUME_EN (adds the volume port).
module audio_mixer_nch
    import mixer_pkg::*;
#(
    parameter  int unsigned NCH        = 3,
    parameter  int unsigned CW         = 8,
    parameter  int unsigned TAPE_LEVEL = DEFAULT_TAPE_LEVEL,
    localparam int unsigned SW         = mix_sum_width(NCH, CW, TAPE_LEVEL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*CW-1:0] ch_data,
    input  logic [2*NCH-1:0]  ch_pan,
    input  logic              mic,
    input  logic              ear,
    input  logic              tape_en,
`ifdef MIXER_VOLUME_EN
    input  logic [2:0]        volume,
`endif
    output logic [SW-1:0]     sample_l,
    output logic [SW-1:0]     sample_r,
    output logic              sample_strobe,
    output logic              audio_out_left,
    output logic              audio_out_right
);

    localparam int unsigned    SLW       = (NCH < 1) ? 1 : $clog2(NCH + 1);
    localparam logic [SLW-1:0] LAST_SLOT = SLW'(NCH);
    localparam logic [SW-1:0]  TL        = SW'(TAPE_LEVEL);

    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("audio_mixer_nch: NCH must be in 1..8");
    end
    if (longint'(TAPE_LEVEL) > (longint'(1) << CW) - 1) begin : g_bad_tape
        $error("audio_mixer_nch: TAPE_LEVEL exceeds channel full scale");
    end
    if (longint'(NCH) * ((longint'(1) << CW) - 1) + 2 * longint'(TAPE_LEVEL) > (longint'(1) << SW) - 1) begin : g_bad_sw
        $error("audio_mixer_nch: SW too narrow for worst-case sum");
    end

    logic [SLW-1:0] slot;
    logic [CW-1:0]  snap [NCH];
    logic [SW-1:0]  acc_l;
    logic [SW-1:0]  acc_r;
    logic [CW-1:0]  ch_term;
    pan_e           pan_sel;
    logic           add_l;
    logic           add_r;
    logic [SW-1:0]  tape_term;

    // The tape slot (slot == NCH) matches no channel and therefore selects a muted zero term.
    always_comb begin
        ch_term = '0;
        pan_sel = PAN_MUTE;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (slot == SLW'(k)) begin
                ch_term = snap[k];
                pan_sel = pan_e'(ch_pan[2*k +: 2]);
            end
        end
`ifdef MIXER_VOLUME_EN
        ch_term = ch_term >> volume;
`endif
        add_l = (pan_sel == PAN_BOTH) || (pan_sel == PAN_LEFT);
        add_r = (pan_sel == PAN_BOTH) || (pan_sel == PAN_RIGHT);
    end

    assign tape_term = tape_en ? ((mic ? TL : '0) + (ear ? TL : '0)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot          <= '0;
            acc_l         <= '0;
            acc_r         <= '0;
            sample_l      <= '0;
            sample_r      <= '0;
            sample_strobe <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) begin
                snap[k] <= '0;
            end
        end else if (slot == LAST_SLOT) begin
            slot          <= '0;
            sample_l      <= acc_l + tape_term;
            sample_r      <= acc_r + tape_term;
            acc_l         <= '0;
            acc_r         <= '0;
            sample_strobe <= 1'b1;
            for (int unsigned k = 0; k < NCH; k++) begin
                snap[k] <= ch_data[k*CW +: CW];
            end
        end else begin
            slot          <= slot + SLW'(1);
            sample_strobe <= 1'b0;
            if (add_l) begin
                acc_l <= acc_l + SW'(ch_term);
            end
            if (add_r) begin
                acc_r <= acc_r + SW'(ch_term);
            end
        end
    end

    sigma_delta_dac #(.W(SW)) u_dac_left (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (sample_l),
        .bit_out (audio_out_left)
    );

    sigma_delta_dac #(.W(SW)) u_dac_right (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (sample_r),
        .bit_out (audio_out_right)
    );

endmodule

// File: tb/tb_audio_mixer_nch.sv
// Self-checking bench for audio_mixer_nch (NCH=3, CW=8): frame-level model plus directed literals.
module tb_audio_mixer_nch;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 8;
    localparam int unsigned SW  = 10;
    localparam int unsigned F   = NCH + 1;
    localparam int unsigned FS  = 1 << SW;
    localparam int unsigned TLV = 'h40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH*CW-1:0] ch_data = '0;
    logic [2*NCH-1:0]  ch_pan = '0;
    logic              mic = 1'b0;
    logic              ear = 1'b0;
    logic              tape_en = 1'b0;
    logic [2:0]        volume = 3'd0;
    logic [SW-1:0]     sample_l;
    logic [SW-1:0]     sample_r;
    logic              sample_strobe;
    logic              audio_out_left;
    logic              audio_out_right;

    int n_pass  = 0;
    int n_total = 0;

    audio_mixer_nch #(.NCH(NCH), .CW(CW), .TAPE_LEVEL(TLV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ch_data         (ch_data),
        .ch_pan          (ch_pan),
        .mic             (mic),
        .ear             (ear),
        .tape_en         (tape_en),
`ifdef MIXER_VOLUME_EN
        .volume          (volume),
`endif
        .sample_l        (sample_l),
        .sample_r        (sample_r),
        .sample_strobe   (sample_strobe),
        .audio_out_left  (audio_out_left),
        .audio_out_right (audio_out_right)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: position within the frame, snapshot, running sums, latched samples, DAC phases.
    int unsigned pos = 0;
    int unsigned m_snap [NCH];
    int unsigned m_acc_l = 0, m_acc_r = 0, m_sl = 0, m_sr = 0;
    int unsigned m_ph_l = 0, m_ph_r = 0;
    bit          m_stb = 0, m_ol = 0, m_or = 0;
    int unsigned m_term, m_tape, m_vol;
    logic [1:0]  m_pan;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos = 0; m_acc_l = 0; m_acc_r = 0; m_sl = 0; m_sr = 0;
            m_ph_l = 0; m_ph_r = 0; m_stb = 0; m_ol = 0; m_or = 0;
            for (int k = 0; k < NCH; k++) m_snap[k] = 0;
        end else begin
            m_ph_l = (m_ph_l % FS) + m_sl;
            m_ph_r = (m_ph_r % FS) + m_sr;
            m_ol   = (m_ph_l >= FS);
            m_or   = (m_ph_r >= FS);
`ifdef MIXER_VOLUME_EN
            m_vol = volume;
`else
            m_vol = 0;
`endif
            m_stb = 0;
            if (pos < NCH) begin
                m_term = m_snap[pos] >> m_vol;
                m_pan  = ch_pan[2*pos +: 2];
                if (m_pan == 2'b00 || m_pan == 2'b01) m_acc_l += m_term;
                if (m_pan == 2'b00 || m_pan == 2'b10) m_acc_r += m_term;
            end else begin
                m_tape = tape_en ? ((mic ? TLV : 0) + (ear ? TLV : 0)) : 0;
                m_sl = m_acc_l + m_tape;
                m_sr = m_acc_r + m_tape;
                m_acc_l = 0;
                m_acc_r = 0;
                for (int k = 0; k < NCH; k++) m_snap[k] = ch_data[k*CW +: CW];
                m_stb = 1;
            end
            pos = (pos + 1) % F;
        end
    end

    always @(negedge clk) begin
        check("cyc_sample_l", sample_l, m_sl);
        check("cyc_sample_r", sample_r, m_sr);
        check("cyc_strobe", sample_strobe, m_stb);
        check("cyc_out_left", audio_out_left, m_ol);
        check("cyc_out_right", audio_out_right, m_or);
    end

    task automatic set_in(input logic [NCH*CW-1:0] d, input logic [2*NCH-1:0] p,
                          input logic te, input logic mc, input logic er);
        @(negedge clk);
        ch_data = d; ch_pan = p; tape_en = te; mic = mc; ear = er;
    endtask

    task automatic wait_strobe(input string name);
        bit seen = 0;
        for (int i = 0; i < 2 * F && !seen; i++) begin
            @(negedge clk);
            if (sample_strobe) seen = 1;
        end
        check({name, "_strobe_seen"}, seen, 1);
    endtask

    task automatic settle_and_check(input string name, input int exp_l, input int exp_r);
        repeat (2 * F) @(negedge clk);
        wait_strobe(name);
        check({name, "_l"}, sample_l, exp_l);
        check({name, "_r"}, sample_r, exp_r);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int cnt, ones_l, ones_r;
        bit b0, b1;

        repeat (2) @(negedge clk);
        check("rst_sample_l", sample_l, 0);
        check("rst_sample_r", sample_r, 0);
        check("rst_strobe", sample_strobe, 0);
        check("rst_out_l", audio_out_left, 0);
        #2 rst_n = 1'b1;

        set_in({8'hFF, 8'hFF, 8'hFF}, 6'b000000, 0, 0, 0);
        settle_and_check("all_ff", 'h2FD, 'h2FD);
        check("model_all_ff", m_sl, 'h2FD);
        cnt = 0;
        for (int i = 0; i < 3 * F; i++) begin
            @(negedge clk);
            cnt++;
            if (sample_strobe) break;
        end
        check("strobe_period", cnt, 4);

        set_in({8'hFF, 8'h40, 8'h80}, 6'b111001, 0, 0, 0);
        settle_and_check("pan_mix", 128, 64);
        check("model_pan_mix", m_sr, 64);

        set_in('0, 6'b000000, 1, 1, 0);
        settle_and_check("tape_mic", 64, 64);
        set_in('0, 6'b000000, 1, 1, 1);
        settle_and_check("tape_both", 128, 128);
        check("model_tape_both", m_sl, 128);
        set_in('0, 6'b000000, 0, 1, 1);
        settle_and_check("tape_off", 0, 0);

        set_in({8'h02, 8'hFF, 8'hFF}, 6'b000000, 0, 0, 0);
        settle_and_check("half_scale", 512, 512);
        @(negedge clk); b0 = audio_out_left;
        @(negedge clk); b1 = audio_out_left;
        check("dac_alternates", b0 ^ b1, 1);
        ones_l = 0; ones_r = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            ones_l += int'(audio_out_left);
            ones_r += int'(audio_out_right);
        end
        check("dac_ones_left", ones_l, 512);
        check("dac_ones_right", ones_r, 512);

        set_in('0, 6'b000000, 0, 0, 0);
        settle_and_check("zero", 0, 0);
        ones_l = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ones_l += int'(audio_out_left) + int'(audio_out_right);
        end
        check("dac_zero_const", ones_l, 0);

        // Reset two slots into a frame, then time the first strobe after release.
        set_in({8'hFF, 8'hFF, 8'hFF}, 6'b000000, 0, 0, 0);
        settle_and_check("pre_reset", 'h2FD, 'h2FD);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sample_l", sample_l, 0);
        check("midrst_sample_r", sample_r, 0);
        check("midrst_strobe", sample_strobe, 0);
        check("midrst_outs", {audio_out_left, audio_out_right}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3 * F; i++) begin
            @(negedge clk);
            cnt++;
            if (sample_strobe) break;
        end
        check("first_strobe_after_rst", cnt, 4);
        check("first_frame_empty", sample_l, 0);
        wait_strobe("second_frame");
        check("second_frame_l", sample_l, 'h2FD);

`ifdef MIXER_VOLUME_EN
        @(negedge clk); volume = 3'd2;
        set_in({8'h00, 8'h00, 8'hFF}, 6'b000000, 0, 0, 0);
        settle_and_check("vol2", 63, 63);
        @(negedge clk); volume = 3'd0;
        settle_and_check("vol0", 255, 255);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
